icmp_server_hls_deadlock_reporter: RTL and testbench

//  Consumer side of the per-kernel HLS deadlock monitor: takes the monitor's block flag and packed
//  per-channel AXIS block info, and confirms a deadlock only after a stall persists for THRESHOLD cycles.
//  On confirmation it latches a snapshot, raises a sticky flag and emits one report beat on an AXIS

---
 rtl/icmp_server_hls_deadlock_reporter_pkg.sv | 25 ++
 rtl/icmp_server_hls_deadlock_reporter_if.sv | 12 +
 rtl/icmp_server_hls_deadlock_reporter_info_decode.sv | 18 +
 rtl/icmp_server_hls_deadlock_reporter.sv | 92 +++++++++
 tb/tb_icmp_server_hls_deadlock_reporter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/icmp_server_hls_deadlock_reporter_pkg.sv
// Shared types and report layout for the HLS deadlock reporter.
// The report word carries a magic byte, a sequence number and the stall snapshot.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    WATCH,
    REPORT,
    HOLD
  } state_t;

  localparam logic [7:0] REPORT_MAGIC = 8'hDE;
  localparam int MAGIC_LSB = 24;
  localparam int SEQ_LSB   = 16;
  localparam int SNAP_LSB  = 0;

  function automatic logic [31:0] build_report(input logic [7:0] seq, input logic [15:0] snapshot);
    logic [31:0] word;
    word = '0;
    word[MAGIC_LSB +: 8] = REPORT_MAGIC;
    word[SEQ_LSB +: 8]   = seq;
    word[SNAP_LSB +: 16] = snapshot;
    return word;
  endfunction

endpackage

// File: rtl/icmp_server_hls_deadlock_reporter_if.sv
// Single-beat AXI-Stream report channel between the reporter and the debug/status path.
interface icmp_server_hls_deadlock_reporter_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/icmp_server_hls_deadlock_reporter_info_decode.sv
// Turns the monitor's packed 2-bit per-channel block info into a one-bit-per-channel mask.
// The mask is forced to zero whenever the monitor is not flagging a block.
module hls_deadlock_info_decode #(
  parameter int CHAN_NUM = 2
) (
  input  logic                  block,
  input  logic [2*CHAN_NUM-1:0] axis_block_info,
  output logic [CHAN_NUM-1:0]   mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      mask[i] = block & (|axis_block_info[2*i +: 2]);
    end
  end

endmodule

// File: rtl/icmp_server_hls_deadlock_reporter.sv
// Confirms an HLS deadlock after THRESHOLD consecutive blocked cycles, latches a snapshot,
// raises a sticky flag and emits exactly one report beat per confirmation.
module icmp_server_hls_deadlock_reporter
  import hls_deadlock_pkg::*;
#(
  parameter int CHAN_NUM  = 2,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  block,
  input  logic [2*CHAN_NUM-1:0] axis_block_info,
  input  logic                  clear,
  output logic                  deadlock,
  output logic [CHAN_NUM-1:0]   blocked_mask,
  output logic [CNT_W-1:0]      stall_cycles,
  icmp_server_hls_deadlock_reporter_if.master m_axis
);

  localparam logic [CNT_W-1:0] CONFIRM_AT     = CNT_W'(THRESHOLD - 1);
  localparam logic [15:0]      STALL_SNAPSHOT = 16'(THRESHOLD);

  state_t              state;
  logic [7:0]          seq;
  logic [31:0]         report_data;
  logic                report_valid;
  logic [CHAN_NUM-1:0] mask;

  hls_deadlock_info_decode #(
    .CHAN_NUM(CHAN_NUM)
  ) u_info_decode (
    .block           (block),
    .axis_block_info (axis_block_info),
    .mask            (mask)
  );

  assign m_axis.tdata  = report_data;
  assign m_axis.tvalid = report_valid;
  assign m_axis.tlast  = report_valid;

  // reset outranks clear, and clear outranks both confirmation and handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= WATCH;
      deadlock     <= 1'b0;
      blocked_mask <= '0;
      stall_cycles <= '0;
      report_valid <= 1'b0;
      report_data  <= '0;
      seq          <= '0;
    end else if (clear) begin
      state        <= WATCH;
      deadlock     <= 1'b0;
      blocked_mask <= '0;
      stall_cycles <= '0;
      report_valid <= 1'b0;
    end else begin
      if (!block) begin
        stall_cycles <= '0;
      end else if (stall_cycles != '1) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end

      case (state)
        WATCH: begin
          if (block && stall_cycles == CONFIRM_AT) begin
            deadlock     <= 1'b1;
            blocked_mask <= mask;
            report_data  <= build_report(seq, STALL_SNAPSHOT);
            report_valid <= 1'b1;
            state        <= REPORT;
          end
        end
        REPORT: begin
          if (m_axis.tready) begin
            report_valid <= 1'b0;
            seq          <= seq + 8'd1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          state <= HOLD;
        end
        default: begin
          state <= WATCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_server_hls_deadlock_reporter.sv
// Randomised scoreboard bench for the deadlock reporter: a run-length reference model predicts
// every cycle's outputs and queues expected report beats for an independent handshake monitor.
module tb_icmp_server_hls_deadlock_reporter;

  localparam int THR     = 1000;
  localparam int CNT_MAX = 65535;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        block;
  logic        clear;
  logic [3:0]  axis_block_info;
  logic        deadlock;
  logic [1:0]  blocked_mask;
  logic [15:0] stall_cycles;

  icmp_server_hls_deadlock_reporter_if m_axis ();

  icmp_server_hls_deadlock_reporter #(
    .CHAN_NUM  (2),
    .CNT_W     (16),
    .THRESHOLD (THR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .block           (block),
    .axis_block_info (axis_block_info),
    .clear           (clear),
    .deadlock        (deadlock),
    .blocked_mask    (blocked_mask),
    .stall_cycles    (stall_cycles),
    .m_axis          (m_axis)
  );

  // narrow counter instance to exercise saturation right at the confirm point
  logic       s_reset;
  logic       s_block;
  logic       s_clear;
  logic [3:0] s_info;
  logic       s_deadlock;
  logic [1:0] s_mask;
  logic [3:0] s_stall;

  icmp_server_hls_deadlock_reporter_if s_axis ();

  icmp_server_hls_deadlock_reporter #(
    .CHAN_NUM  (2),
    .CNT_W     (4),
    .THRESHOLD (15)
  ) dut_small (
    .clock           (clock),
    .reset           (s_reset),
    .block           (s_block),
    .axis_block_info (s_info),
    .clear           (s_clear),
    .deadlock        (s_deadlock),
    .blocked_mask    (s_mask),
    .stall_cycles    (s_stall),
    .m_axis          (s_axis)
  );

  int checks = 0;
  int errors = 0;

  // reference model: values expected just after the next clock edge
  int          m_run      = 0;
  int          m_seq      = 0;
  int          m_beats    = 0;
  int          seen_beats = 0;
  bit          m_dead     = 1'b0;
  bit          m_pending  = 1'b0;
  bit          m_after_reset = 1'b0;
  logic [1:0]  m_mask     = 2'b00;
  logic [31:0] exp_q[$];

  function automatic logic [1:0] model_mask(input logic [3:0] info);
    logic [1:0] m;
    for (int i = 0; i < 2; i++) begin
      m[i] = (((info >> (2 * i)) & 4'h3) != 4'h0);
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic predict();
    logic [31:0] word;
    logic [7:0]  seq8;
    if (reset) begin
      if (m_pending) void'(exp_q.pop_back());
      m_run = 0; m_dead = 0; m_mask = 2'b00; m_pending = 0; m_seq = 0; m_after_reset = 1;
    end else if (clear) begin
      if (m_pending) void'(exp_q.pop_back());
      m_run = 0; m_dead = 0; m_mask = 2'b00; m_pending = 0; m_after_reset = 0;
    end else begin
      m_after_reset = 0;
      if (m_pending && m_axis.tready) begin
        m_pending = 0;
        m_seq = (m_seq + 1) % 256;
        m_beats++;
      end
      m_run = block ? m_run + 1 : 0;
      if (!m_dead && m_run == THR) begin
        m_dead    = 1;
        m_mask    = model_mask(axis_block_info);
        m_pending = 1;
        seq8      = 8'(m_seq);
        word      = {8'hDE, seq8, 16'(THR)};
        exp_q.push_back(word);
      end
    end
  endtask

  task automatic check_output();
    int exp_stall;
    exp_stall = (m_run > CNT_MAX) ? CNT_MAX : m_run;
    check("deadlock", 32'(deadlock), 32'(m_dead));
    check("blocked_mask", 32'(blocked_mask), 32'(m_mask));
    check("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
    check("tvalid", 32'(m_axis.tvalid), 32'(m_pending));
    check("tlast", 32'(m_axis.tlast), 32'(m_pending));
    if (m_pending && exp_q.size() > 0) check("tdata_held", m_axis.tdata, exp_q[0]);
    if (m_after_reset) check("tdata_reset", m_axis.tdata, 32'h0);
  endtask

  task automatic apply_stimulus(input logic b, input logic [3:0] info, input logic rdy,
                                input logic clr, input logic rst, input int n);
    for (int c = 0; c < n; c++) begin
      block           = b;
      axis_block_info = info;
      m_axis.tready   = rdy;
      clear           = clr;
      reset           = rst;
      predict();
      @(posedge clock);
      #1;
      check_output();
    end
  endtask

  // handshake monitor: pops the scoreboard whenever the DUT's beat is accepted
  initial begin
    logic [31:0] want;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && clear === 1'b0 && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
        seen_beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%h expected=none at %0t", m_axis.tdata, $time);
        end else begin
          want = exp_q.pop_front();
          check("beat_tdata", m_axis.tdata, want);
          check("beat_tlast", 32'(m_axis.tlast), 32'h1);
        end
      end
    end
  end

  initial begin
    int len;
    logic [3:0] rinfo;
    s_reset = 1'b1; s_block = 1'b0; s_clear = 1'b0; s_info = 4'b0000;
    s_axis.tready = 1'b1;

    apply_stimulus(0, 4'b0000, 0, 0, 1, 3);

    // confirm with ready sink, then hold with no second beat
    apply_stimulus(1, 4'b0110, 1, 0, 0, 1010);
    apply_stimulus(0, 4'b0110, 1, 0, 0, 3);
    apply_stimulus(0, 4'b0000, 1, 1, 0, 1);

    // one cycle short of the threshold
    apply_stimulus(1, 4'b1111, 1, 0, 0, 999);
    apply_stimulus(0, 4'b1111, 1, 0, 0, 2);

    // backpressured report, then a second confirmation with the next sequence number
    apply_stimulus(0, 4'b0000, 0, 0, 1, 2);
    apply_stimulus(1, 4'b0110, 0, 0, 0, 1000);
    apply_stimulus(1, 4'b0110, 0, 0, 0, 20);
    apply_stimulus(1, 4'b0110, 1, 0, 0, 2);
    apply_stimulus(0, 4'b0000, 1, 1, 0, 1);
    apply_stimulus(1, 4'b1001, 1, 0, 0, 1003);
    apply_stimulus(0, 4'b0000, 1, 1, 0, 1);

    // clear discards an unacknowledged report; next report reuses seq 0
    apply_stimulus(0, 4'b0000, 0, 0, 1, 2);
    apply_stimulus(1, 4'b0100, 0, 0, 0, 1003);
    apply_stimulus(1, 4'b0100, 0, 1, 0, 1);
    apply_stimulus(1, 4'b0010, 1, 0, 0, 1003);
    apply_stimulus(0, 4'b0000, 1, 1, 0, 1);

    // reset mid-report, and clear colliding with the confirm cycle
    apply_stimulus(1, 4'b1100, 0, 0, 0, 1002);
    apply_stimulus(1, 4'b1100, 0, 0, 1, 1);
    apply_stimulus(0, 4'b0000, 0, 0, 0, 1);
    apply_stimulus(1, 4'b0011, 1, 0, 0, 999);
    apply_stimulus(1, 4'b0011, 1, 1, 0, 1);
    apply_stimulus(1, 4'b0011, 1, 0, 0, 5);
    apply_stimulus(0, 4'b0000, 1, 0, 0, 2);

    // randomised runs around the threshold with random backpressure and clears
    for (int seg = 0; seg < 12; seg++) begin
      len   = $urandom_range(960, 1040);
      rinfo = 4'($urandom_range(0, 15));
      for (int c = 0; c < len; c++) begin
        apply_stimulus(1, rinfo, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 599) == 0), 0, 1);
      end
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) begin
        apply_stimulus(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, 0, 1);
      end
      if ($urandom_range(0, 1) == 1) apply_stimulus(0, 4'b0000, 1, 1, 0, 1);
    end
    apply_stimulus(0, 4'b0000, 1, 0, 0, 3);
    check("beat_count", 32'(seen_beats), 32'(m_beats));

    // narrow counter: confirm at 15 blocked cycles, then saturate at all-ones
    @(posedge clock); #1;
    s_reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      s_block = 1'b1;
      s_info  = 4'b0010;
      @(posedge clock); #1;
      check("small_stall", 32'(s_stall), 32'((k > 15) ? 15 : k));
      check("small_deadlock", 32'(s_deadlock), 32'(k >= 15));
      check("small_mask", 32'(s_mask), (k >= 15) ? 32'h1 : 32'h0);
      check("small_tvalid", 32'(s_axis.tvalid), 32'(k == 15));
      if (k == 15) check("small_tdata", s_axis.tdata, 32'hDE00_000F);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
